// File: rtl/key_tx_pkg.sv
// Shared state encoding, ASCII constants and nibble-to-hex helper for the keypad UART path.
package key_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } tx_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
        logic [7:0] chr;
        if (nib < 4'd10) begin
            chr = 8'h30 + {4'h0, nib};
        end else begin
            chr = 8'h37 + {4'h0, nib};
        end
        return chr;
    endfunction

endpackage

// File: rtl/key_strobe_sync.sv
// Brings the keypad strobe/code pair into the clock domain and emits a one-cycle
// push pulse, with the matching synchronized code, on each rising strobe edge.
module key_strobe_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       strobe,
    input  logic [3:0] code,
    output logic       push,
    output logic [3:0] code_out
);

    logic [4:0] meta_r;
    logic [4:0] sync_r;
    logic       prev_r;
    logic       push_r;
    logic [3:0] code_r;

    // Two-flop synchronizer followed by a registered rising-edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 5'h00;
            sync_r <= 5'h00;
            prev_r <= 1'b0;
            push_r <= 1'b0;
            code_r <= 4'h0;
        end else begin
            meta_r <= {strobe, code};
            sync_r <= meta_r;
            prev_r <= sync_r[4];
            push_r <= sync_r[4] & ~prev_r;
            code_r <= sync_r[3:0];
        end
    end

    assign push     = push_r;
    assign code_out = code_r;

endmodule

// File: rtl/key_uart_tx.sv
// Keypad transmit path: queues key presses in a FIFO and sends each as an ASCII hex
// character over the txdata/txclk/txready handshake. KEY_UART_TX_CRLF_EN appends CR LF.
module key_uart_tx
    import key_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   hz100,
    input  logic                   reset,
    input  logic [3:0]             code,
    input  logic                   strobe,
    input  logic                   txready,
    output logic [7:0]             txdata,
    output logic                   txclk,
    output logic                   busy,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic          push_s;
    logic [3:0]    sync_code_s;

    logic [3:0]    mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          overflow_r;
    logic          ovf_nxt_s;
    logic          full_s;
    logic          wr_en_s;
    logic          pop_s;
    logic [3:0]    head_s;

    tx_state_t     state_r;
    tx_state_t     state_nxt_s;
    logic [7:0]    txdata_r;
    logic [7:0]    txdata_nxt_s;
    logic          txclk_r;
    logic          busy_r;
    logic          busy_nxt_s;
    logic          start_s;

`ifdef KEY_UART_TX_CRLF_EN
    logic [1:0]    idx_r;
    logic [1:0]    idx_nxt_s;
`endif

    key_strobe_sync u_sync (
        .clk      (hz100),
        .rst_n    (reset),
        .strobe   (strobe),
        .code     (code),
        .push     (push_s),
        .code_out (sync_code_s)
    );

    assign head_s = mem_r[rd_ptr_r];

    // FIFO bookkeeping; a pop in the same cycle frees the slot a full-FIFO push needs.
    always_comb begin
        full_s    = (count_r == FULL_C);
        wr_en_s   = push_s && (!full_s || pop_s);
        ovf_nxt_s = overflow_r | (push_s && full_s && !pop_s);
        case ({wr_en_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage, pointers, occupancy and sticky overflow flag.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 4'h0;
            end
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= sync_code_s;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r    <= count_nxt_s;
            overflow_r <= ovf_nxt_s;
        end
    end

    // Start condition and next-cycle busy flag.
    always_comb begin
`ifdef KEY_UART_TX_CRLF_EN
        start_s    = txready && ((count_r != {CW{1'b0}}) || (idx_r != 2'd0));
        busy_nxt_s = (state_nxt_s != IDLE) || (count_nxt_s != {CW{1'b0}}) || (idx_nxt_s != 2'd0);
`else
        start_s    = txready && (count_r != {CW{1'b0}});
        busy_nxt_s = (state_nxt_s != IDLE) || (count_nxt_s != {CW{1'b0}});
`endif
    end

    // Transmit FSM next-state and data selection.
    always_comb begin
        state_nxt_s  = state_r;
        txdata_nxt_s = txdata_r;
        pop_s        = 1'b0;
`ifdef KEY_UART_TX_CRLF_EN
        idx_nxt_s    = idx_r;
`endif
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_nxt_s = SETUP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETUP: begin
                state_nxt_s = PULSE;
`ifdef KEY_UART_TX_CRLF_EN
                case (idx_r)
                    2'd0: begin
                        pop_s        = 1'b1;
                        txdata_nxt_s = hex2ascii(head_s);
                    end
                    2'd1:    txdata_nxt_s = ASCII_CR;
                    default: txdata_nxt_s = ASCII_LF;
                endcase
`else
                pop_s        = 1'b1;
                txdata_nxt_s = hex2ascii(head_s);
`endif
            end
            PULSE: begin
                state_nxt_s = HOLD;
            end
            HOLD: begin
                if (!txready) begin
                    state_nxt_s = IDLE;
`ifdef KEY_UART_TX_CRLF_EN
                    if (idx_r == 2'd2) begin
                        idx_nxt_s = 2'd0;
                    end else begin
                        idx_nxt_s = idx_r + 2'd1;
                    end
`endif
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state and registered UART-facing outputs; txclk is high only in PULSE.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            txdata_r <= 8'h00;
            txclk_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            txdata_r <= txdata_nxt_s;
            txclk_r  <= (state_nxt_s == PULSE);
            busy_r   <= busy_nxt_s;
        end
    end

`ifdef KEY_UART_TX_CRLF_EN
    // Byte index within the current entry: hex char, CR, LF.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            idx_r <= 2'd0;
        end else begin
            idx_r <= idx_nxt_s;
        end
    end
`endif

    assign txdata   = txdata_r;
    assign txclk    = txclk_r;
    assign busy     = busy_r;
    assign overflow = overflow_r;
    assign count    = count_r;

endmodule

// File: tb/tb_key_uart_tx.sv
// Self-checking bench for key_uart_tx: table of key codes plus hand-written corner cases,
// with a byte scoreboard fed at press time and drained on each txclk pulse.
module tb_key_uart_tx;

    logic       hz100 = 1'b0;
    logic       reset;
    logic [3:0] code;
    logic       strobe;
    logic       txready;
    logic [7:0] txdata;
    logic       txclk;
    logic       busy;
    logic       overflow;
    logic [2:0] count;

    key_uart_tx #(.DEPTH(4)) dut (
        .hz100    (hz100),
        .reset    (reset),
        .code     (code),
        .strobe   (strobe),
        .txready  (txready),
        .txdata   (txdata),
        .txclk    (txclk),
        .busy     (busy),
        .overflow (overflow),
        .count    (count)
    );

    always #5 hz100 = ~hz100;

`ifdef KEY_UART_TX_CRLF_EN
    localparam int BYTES = 3;
`else
    localparam int BYTES = 1;
`endif

    typedef struct {
        logic [3:0] key;
        logic [7:0] ascii;
    } vec_t;

    localparam logic [7:0] ASC [16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                                        8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};

    vec_t       vecs [16];
    logic [7:0] exp_q [$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_pulse  = 0;
    bit         auto_ack = 1'b0;
    int         ack_cnt  = 0;
    logic       prev_txclk = 1'b0;
    int         p0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge, score txclk pulses, emulate UART ack.
    task automatic tick();
        logic [7:0] e;
        @(negedge hz100);
        if (txclk === 1'b1) begin
            n_pulse++;
            check("txclk_width", 32'(prev_txclk), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_byte", 32'(txdata), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("txdata", 32'(txdata), 32'(e));
            end
            if (auto_ack) ack_cnt = 3;
        end
        if (auto_ack) begin
            if (ack_cnt != 0) begin
                txready = 1'b0;
                ack_cnt--;
            end else begin
                txready = 1'b1;
            end
        end
        prev_txclk = txclk;
    endtask

    task automatic expect_entry(input logic [7:0] b);
        exp_q.push_back(b);
`ifdef KEY_UART_TX_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic press(input logic [3:0] k, input logic [7:0] b, input bit kept,
                         input int hold, input int gap);
        code   = k;
        strobe = 1'b1;
        if (kept) expect_entry(b);
        repeat (hold) tick();
        strobe = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < max) begin
            tick();
            n++;
        end
        check("drain_in_time", 32'(n < max), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            vecs[i].key   = 4'(i);
            vecs[i].ascii = ASC[i];
        end
        reset   = 1'b0;
        code    = 4'h0;
        strobe  = 1'b0;
        txready = 1'b1;
        repeat (3) @(negedge hz100);
        check("rst_txdata", 32'(txdata), 32'd0);
        check("rst_txclk", 32'(txclk), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        reset = 1'b1;
        tick();

        // Latency of a single press with an idle, ready UART.
        p0 = n_pulse;
        code = 4'hA;
        strobe = 1'b1;
        expect_entry(8'h41);
        repeat (3) tick();
        check("lat_count_c2", 32'(count), 32'd0);
        tick();
        check("lat_count_c3", 32'(count), 32'd1);
        check("lat_busy_c3", 32'(busy), 32'd1);
        tick();
        check("lat_txclk_c4", 32'(txclk), 32'd0);
        tick();
        check("lat_txclk_c5", 32'(txclk), 32'd1);
        check("lat_count_c5", 32'(count), 32'd0);
        repeat (14) tick();
        strobe = 1'b0;
        repeat (5) tick();
        check("single_pulse", 32'(n_pulse - p0), 32'd1);
        check("hold_busy", 32'(busy), 32'd1);
        txready = 1'b0;
        repeat (2) tick();
        txready = 1'b1;
        auto_ack = 1'b1;
        drain(200);
        check("t1_busy_idle", 32'(busy), 32'd0);
        check("t1_count", 32'(count), 32'd0);

        // Fill FIFO with UART not ready; fifth press is dropped.
        auto_ack = 1'b0;
        txready  = 1'b0;
        p0 = n_pulse;
        press(4'h3, 8'h33, 1'b1, 3, 3);
        press(4'h7, 8'h37, 1'b1, 3, 3);
        press(4'hC, 8'h43, 1'b1, 3, 3);
        press(4'hF, 8'h46, 1'b1, 3, 3);
        press(4'h0, 8'h30, 1'b0, 3, 5);
        check("full_count", 32'(count), 32'd4);
        check("full_overflow", 32'(overflow), 32'd1);
        check("full_no_tx", 32'(n_pulse - p0), 32'd0);
        auto_ack = 1'b1;
        drain(400);
        check("full_drained", 32'(n_pulse - p0), 32'(4 * BYTES));
        check("overflow_sticky", 32'(overflow), 32'd1);

        // Long key hold gives one entry only.
        p0 = n_pulse;
        press(4'h5, 8'h35, 1'b1, 100, 3);
        drain(200);
        check("hold_one_entry", 32'(n_pulse - p0), 32'(BYTES));

        // Full hex map, one entry at a time.
        for (int i = 0; i < 16; i++) begin
            p0 = n_pulse;
            press(vecs[i].key, vecs[i].ascii, 1'b1, 3, 2);
            drain(200);
            check("map_pulses", 32'(n_pulse - p0), 32'(BYTES));
        end

        // Asynchronous reset in the middle of a txclk pulse.
        p0 = n_pulse;
        code = 4'h6;
        strobe = 1'b1;
        expect_entry(8'h36);
        while (n_pulse == p0 && (n_pulse - p0) < 1 && p0 + 100 > n_pulse + 0) begin
            tick();
            if (n_pulse == p0 && txclk === 1'b0 && exp_q.size() == 0) break;
            if (prev_txclk === 1'b1) break;
        end
        check("pulse_seen_before_rst", 32'(txclk), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_txclk", 32'(txclk), 32'd0);
        check("rst_mid_count", 32'(count), 32'd0);
        check("rst_mid_overflow", 32'(overflow), 32'd0);
        check("rst_mid_txdata", 32'(txdata), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        strobe = 1'b0;
        exp_q.delete();
        repeat (3) tick();
        reset = 1'b1;
        tick();
        p0 = n_pulse;
        press(4'h8, 8'h38, 1'b1, 3, 2);
        drain(200);
        check("after_rst_tx", 32'(n_pulse - p0), 32'(BYTES));

        // UART keeps txready high after a byte: FSM parks in HOLD.
        auto_ack = 1'b0;
        txready  = 1'b1;
        p0 = n_pulse;
        press(4'h1, 8'h31, 1'b1, 3, 3);
        press(4'h2, 8'h32, 1'b1, 3, 3);
        repeat (20) tick();
        check("stuck_hold_pulses", 32'(n_pulse - p0), 32'd1);
        check("stuck_hold_count", 32'(count), 32'd1);
        check("stuck_hold_busy", 32'(busy), 32'd1);
        txready = 1'b0;
        repeat (2) tick();
        txready  = 1'b1;
        auto_ack = 1'b1;
        drain(300);
        check("resume_pulses", 32'(n_pulse - p0), 32'(2 * BYTES));

`ifdef KEY_UART_TX_CRLF_EN
        // CR/LF suffix: three bytes from one pop.
        p0 = n_pulse;
        press(4'h9, 8'h39, 1'b1, 3, 2);
        drain(200);
        check("crlf_pulses", 32'(n_pulse - p0), 32'd3);
        check("crlf_count", 32'(count), 32'd0);
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
